// File: rtl/irq_controller.sv
// irq_controller: latches edge-triggered interrupt sources, masks them,
// picks the lowest-numbered one and hands it to the CPU (req/ack/EOI).
//
// Optional feature macro: IRQC_TIMER_CLR_EN
//   defined   - EOI for TIMER_SRC runs a read-modify-write on the timer
//               register port that clears TCON[2] (TRD -> TWR states).
//   undefined - no timer sequencing; tmr_* outputs are tied to 0 and
//               software clears TCON[2] itself.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-low
//   irq_src    level interrupt lines (edge-detected internally)
//   cpu_we     CPU register write strobe
//   cpu_addr   0 MASK, 1 PENDING (W1C), 2 CAUSE (RO), 3 EOI (WO)
//   cpu_wdata  CPU write data
//   cpu_rdata  combinational read of cpu_addr (EOI reads 0)
//   irq_out    interrupt request to CPU
//   irq_ack    1-cycle pulse: CPU entered the handler
//   tmr_busy   controller owns the timer register port
//   tmr_we     timer write strobe
//   tmr_addr   timer register address (2 = TCON)
//   tmr_wdata  timer write data
//   tmr_rdata  timer combinational read data

module irq_controller #(
    parameter int NSRC      = 4,
    parameter int TIMER_SRC = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic            cpu_we,
    input  logic [1:0]      cpu_addr,
    input  logic [31:0]     cpu_wdata,
    output logic [31:0]     cpu_rdata,
    output logic            irq_out,
    input  logic            irq_ack,
    output logic            tmr_busy,
    output logic            tmr_we,
    output logic [1:0]      tmr_addr,
    output logic [31:0]     tmr_wdata,
    input  logic [31:0]     tmr_rdata
);

    localparam logic [1:0] A_MASK  = 2'd0;
    localparam logic [1:0] A_PEND  = 2'd1;
    localparam logic [1:0] A_CAUSE = 2'd2;
    localparam logic [1:0] A_EOI   = 2'd3;

    localparam logic [1:0]  TCON_ADDR = 2'd2;
    localparam logic [31:0] TCON_IRQ  = 32'h0000_0004;

`ifdef IRQC_TIMER_CLR_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_SERV,
        S_TRD,
        S_TWR
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SERV
    } state_t;
`endif

    state_t state_q;
    state_t state_d;

    logic [NSRC-1:0] prev_q;
    logic [NSRC-1:0] mask_q;
    logic [NSRC-1:0] pend_q;
    logic [NSRC-1:0] pend_d;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] hit;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] ack_clr;
    logic [4:0]      id_q;
    logic [4:0]      sel_id;

    logic mask_we;
    logic pend_we;
    logic eoi;
    logic take;

    assign mask_we = cpu_we && (cpu_addr == A_MASK);
    assign pend_we = cpu_we && (cpu_addr == A_PEND);
    assign eoi     = cpu_we && (cpu_addr == A_EOI);

    // Edge detect: a held level raises only one request.
    assign rise = irq_src & ~prev_q;
    assign hit  = pend_q & mask_q;
    assign take = (state_q == S_IDLE) && (|hit);

    assign w1c = pend_we ? cpu_wdata[NSRC-1:0] : '0;

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NSRC; i++) begin
            ack_clr[i] = (state_q == S_REQ) && irq_ack
                         && (id_q == 5'(i));
        end
    end

    // A new edge wins over a same-cycle software or ack clear.
    assign pend_d = (pend_q & ~w1c & ~ack_clr) | rise;

    // Fixed priority: lowest index wins.
    always_comb begin
        sel_id = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel_id = 5'(i);
            end
        end
    end

    // The line history keeps sampling during reset so that a level
    // already high at release is not seen as a fresh edge.
    always_ff @(posedge clk) begin
        prev_q <= irq_src;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mask_q <= '0;
            pend_q <= '0;
            id_q   <= '0;
        end else begin
            if (mask_we) begin
                mask_q <= cpu_wdata[NSRC-1:0];
            end
            pend_q <= pend_d;
            if (take) begin
                id_q <= sel_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef IRQC_TIMER_CLR_EN
    logic [31:0] tcon_q;
    logic        busy_c;
    logic        we_c;
    logic [1:0]  addr_c;
    logic [31:0] wdata_c;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tcon_q <= '0;
        end else if (state_q == S_TRD) begin
            tcon_q <= tmr_rdata;
        end
    end

    always_comb begin
        state_d = state_q;
        irq_out = 1'b0;
        busy_c  = 1'b0;
        we_c    = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        unique case (state_q)
            S_IDLE: begin
                if (|hit) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                irq_out = 1'b1;
                if (irq_ack) begin
                    state_d = S_SERV;
                end
            end
            S_SERV: begin
                if (eoi) begin
                    if (id_q == 5'(TIMER_SRC)) begin
                        state_d = S_TRD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_TRD: begin
                busy_c  = 1'b1;
                addr_c  = TCON_ADDR;
                state_d = S_TWR;
            end
            S_TWR: begin
                busy_c  = 1'b1;
                we_c    = 1'b1;
                addr_c  = TCON_ADDR;
                wdata_c = tcon_q & ~TCON_IRQ;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tmr_busy  = busy_c;
    assign tmr_we    = we_c;
    assign tmr_addr  = addr_c;
    assign tmr_wdata = wdata_c;

    logic unused_in;
    assign unused_in = ^cpu_wdata;
`else
    always_comb begin
        state_d = state_q;
        irq_out = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (|hit) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                irq_out = 1'b1;
                if (irq_ack) begin
                    state_d = S_SERV;
                end
            end
            S_SERV: begin
                if (eoi) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tmr_busy  = 1'b0;
    assign tmr_we    = 1'b0;
    assign tmr_addr  = '0;
    assign tmr_wdata = '0;

    logic unused_in;
    assign unused_in = ^{cpu_wdata, tmr_rdata, TCON_ADDR, TCON_IRQ,
                         (id_q == 5'(TIMER_SRC))};
`endif

    always_comb begin
        cpu_rdata = '0;
        unique case (cpu_addr)
            A_MASK:  cpu_rdata = 32'(mask_q);
            A_PEND:  cpu_rdata = 32'(pend_q);
            A_CAUSE: cpu_rdata = {(state_q != S_IDLE), 26'd0, id_q};
            A_EOI:   cpu_rdata = '0;
            default: cpu_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed vectors for irq_controller
// (NSRC=4, TIMER_SRC=0), both builds of IRQC_TIMER_CLR_EN.

module tb_irq_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq_src;
    logic        cpu_we;
    logic [1:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        irq_out;
    logic        irq_ack;
    logic        tmr_busy;
    logic        tmr_we;
    logic [1:0]  tmr_addr;
    logic [31:0] tmr_wdata;
    logic [31:0] tmr_rdata;

    int n_cmp = 0;
    int n_err = 0;
    int we_cnt = 0;
    int busy_cnt = 0;

    irq_controller #(.NSRC(4), .TIMER_SRC(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_src   (irq_src),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .irq_out   (irq_out),
        .irq_ack   (irq_ack),
        .tmr_busy  (tmr_busy),
        .tmr_we    (tmr_we),
        .tmr_addr  (tmr_addr),
        .tmr_wdata (tmr_wdata),
        .tmr_rdata (tmr_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tmr_we) we_cnt++;
        if (tmr_busy) busy_cnt++;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        step();
        cpu_we    = 1'b0;
        cpu_wdata = '0;
    endtask

    task automatic rd(input string tag, input logic [1:0] a,
                      input logic [31:0] exp);
        cpu_addr = a;
        #1;
        check(tag, cpu_rdata, exp);
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        irq_src   = 4'hF;
        cpu_we    = 1'b0;
        cpu_addr  = 2'd0;
        cpu_wdata = '0;
        irq_ack   = 1'b0;
        tmr_rdata = '0;

        // 1. reset with all lines high
        step();
        step();
        check("rst_irq", 32'(irq_out), 32'd0);
        check("rst_busy", 32'(tmr_busy), 32'd0);
        check("rst_we", 32'(tmr_we), 32'd0);
        check("rst_taddr", 32'(tmr_addr), 32'd0);
        check("rst_twdata", tmr_wdata, 32'd0);
        rd("rst_cause", 2'd2, 32'h0);
        rd("rst_mask", 2'd0, 32'h0);
        rd("rst_pend", 2'd1, 32'h0);
        reset = 1'b1;
        step();
        step();
        check("rel_irq", 32'(irq_out), 32'd0);
        rd("rel_cause", 2'd2, 32'h0);
        irq_src = 4'h0;
        step();

        // 2. priority between two simultaneous sources
        wr(2'd0, 32'hFFFF_FFFF);
        rd("mask_trunc", 2'd0, 32'h0000_000F);
        irq_src = 4'b0110;
        step();
        check("p_irq0", 32'(irq_out), 32'd0);
        rd("p_pend", 2'd1, 32'h6);
        step();
        check("p_irq1", 32'(irq_out), 32'd1);
        rd("p_cause1", 2'd2, 32'h8000_0001);
        ack();
        check("p_serv_irq", 32'(irq_out), 32'd0);
        rd("p_pend_ack", 2'd1, 32'h4);
        rd("p_cause_srv", 2'd2, 32'h8000_0001);
        wr(2'd3, 32'h0);
        rd("p_cause_idle", 2'd2, 32'h0000_0001);
        step();
        check("p_irq2", 32'(irq_out), 32'd1);
        rd("p_cause2", 2'd2, 32'h8000_0002);
        ack();
        wr(2'd3, 32'h0);

        // 4. held level gives one request only
        step();
        step();
        check("held_irq", 32'(irq_out), 32'd0);
        rd("held_pend", 2'd1, 32'h0);
        irq_src = 4'b0100;
        step();
        irq_src = 4'b0110;
        step();
        step();
        check("re_irq", 32'(irq_out), 32'd1);
        rd("re_cause", 2'd2, 32'h8000_0001);
        ack();
        wr(2'd3, 32'h0);
        irq_src = 4'h0;
        step();

        // mask cleared in REQ; EOI in REQ ignored
        wr(2'd0, 32'h8);
        irq_src = 4'b1000;
        step();
        step();
        wr(2'd0, 32'h0);
        wr(2'd3, 32'h0);
        check("mreq_irq", 32'(irq_out), 32'd1);
        rd("mreq_cause", 2'd2, 32'h8000_0003);
        ack();
        check("mreq_serv", 32'(irq_out), 32'd0);
        wr(2'd3, 32'h0);
        rd("mreq_idle", 2'd2, 32'h0000_0003);
        irq_src = 4'h0;
        step();

        // 5. set beats same-cycle W1C; ack outside REQ ignored
        irq_src   = 4'b0010;
        cpu_we    = 1'b1;
        cpu_addr  = 2'd1;
        cpu_wdata = 32'h2;
        step();
        cpu_we    = 1'b0;
        rd("w1c_set", 2'd1, 32'h2);
        check("masked_irq", 32'(irq_out), 32'd0);
        ack();
        rd("ack_idle", 2'd1, 32'h2);
        wr(2'd1, 32'hFFFF_FFFD);
        rd("w1c_zero", 2'd1, 32'h2);
        wr(2'd1, 32'h2);
        rd("w1c_clr", 2'd1, 32'h0);
        irq_src = 4'h0;
        step();

        // 3. timer source EOI
        wr(2'd0, 32'h1);
        tmr_rdata = 32'h7;
        irq_src = 4'b0001;
        step();
        step();
        check("t_irq", 32'(irq_out), 32'd1);
        rd("t_cause", 2'd2, 32'h8000_0000);
        ack();
        wr(2'd3, 32'h0);
`ifdef IRQC_TIMER_CLR_EN
        check("trd_busy", 32'(tmr_busy), 32'd1);
        check("trd_addr", 32'(tmr_addr), 32'd2);
        check("trd_we", 32'(tmr_we), 32'd0);
        rd("trd_cause", 2'd2, 32'h8000_0000);
        step();
        check("twr_we", 32'(tmr_we), 32'd1);
        check("twr_addr", 32'(tmr_addr), 32'd2);
        check("twr_wdata", tmr_wdata, 32'h3);
        check("twr_busy", 32'(tmr_busy), 32'd1);
        step();
        check("tdone_busy", 32'(tmr_busy), 32'd0);
        check("tdone_we", 32'(tmr_we), 32'd0);
        rd("tdone_cause", 2'd2, 32'h0);

        // 6. reset while in TRD
        irq_src = 4'h0;
        step();
        irq_src = 4'b0001;
        step();
        step();
        ack();
        wr(2'd3, 32'h0);
        check("rtrd_busy", 32'(tmr_busy), 32'd1);
        reset = 1'b0;
        #1;
        check("rtrd_we", 32'(tmr_we), 32'd0);
        step();
        reset = 1'b1;
        check("rtrd_we2", 32'(tmr_we), 32'd0);
        check("rtrd_busy2", 32'(tmr_busy), 32'd0);
        rd("rtrd_cause", 2'd2, 32'h0);
        step();
        check("rtrd_we3", 32'(tmr_we), 32'd0);
        step();
        check("we_total", 32'(we_cnt), 32'd1);
        check("busy_total", 32'(busy_cnt), 32'd3);
`else
        check("off_busy", 32'(tmr_busy), 32'd0);
        check("off_we", 32'(tmr_we), 32'd0);
        check("off_addr", 32'(tmr_addr), 32'd0);
        rd("off_cause", 2'd2, 32'h0);
        step();
        step();
        check("we_total", 32'(we_cnt), 32'd0);
        check("busy_total", 32'(busy_cnt), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
